mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (read-only) and the load/store unit (read/write).
- Round-robin arbitration with one outstanding transaction at a time.
- Response-timeout watchdog.
- Sits between instructionFetchController/LSU and the external memory interface; replaces the direct memoryIn feed.

Parameters:
- DATA_WIDTH, 32, data and address width (matches global DATA_WIDTH).
- LSU_PRIORITY, 0, 1 = LSU wins every tie; 0 = round-robin.
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  active-low synchronous reset
- fetch_req  in  1  fetch read request; held until fetch_gnt
- fetch_addr  in  DATA_WIDTH  fetch address
- fetch_gnt  out  1  pulse: memory accepted fetch request
- fetch_rvalid  out  1  fetch read data valid
- fetch_err  out  1  pulse: fetch timed out
- lsu_req  in  1  LSU request; held until lsu_gnt
- lsu_we  in  1  1 = write
- lsu_addr  in  DATA_WIDTH  LSU address
- lsu_wdata  in  DATA_WIDTH  write data
- lsu_wmask  in  4  byte write mask
- lsu_gnt  out  1  pulse: memory accepted LSU request
- lsu_rvalid  out  1  LSU read data / write ack valid
- lsu_err  out  1  pulse: LSU timed out
- rdata  out  DATA_WIDTH  read data, shared by both requesters
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/DW/DW/4  registered request fields
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  response valid (read data or write ack)
- mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is synchronous and active-low.
- Reset values: state=IDLE; mem_req=0; mem_* fields=0; all gnt/rvalid/err=0; last_grant=LSU, so fetch wins the first tie; timeout counter=0.
- Reset asserted mid-transaction aborts it silently: no err pulse, and any later response is dropped.
- State IDLE:
  - If any request is pending, pick an owner.
  - Both pending: LSU if LSU_PRIORITY=1, else the requester that is not last_grant.
  - Latch owner and that owner's request fields into the mem_* registers; next state ISSUE.
  - mem_rvalid arriving in IDLE is dropped.
- State ISSUE:
  - mem_req=1.
  - On mem_ready: owner gnt pulses 1 cycle (same cycle); last_grant←owner; counter←0; next state WAIT.
  - mem_rvalid in ISSUE is ignored.
  - No timeout in ISSUE.
- State WAIT:
  - mem_req=0; counter increments each cycle.
  - On mem_rvalid: owner rvalid=1 combinationally that cycle; rdata=mem_rdata; next state IDLE.
  - Else, if TIMEOUT_CYCLES≠0 and counter==TIMEOUT_CYCLES-1: owner err pulses 1 cycle; next state IDLE.
  - If mem_rvalid and timeout coincide, the response wins and no err is raised.
- rdata: mirrors mem_rdata at all times; meaningful only with rvalid.
- Throughput: at least one IDLE cycle between transactions.
  - Minimum latency from req to rvalid is 3 cycles, with mem_ready and mem_rvalid both 1-cycle.
- Requester fields are sampled only in IDLE; changes after that are ignored until the next arbitration.
- Requester whose req drops before grant: if already latched, the transaction still completes.
- Fairness: with LSU_PRIORITY=0 and both requesting continuously, grants strictly alternate.

Decomposition:
- globalVariables.v: add ARB_STATE_WIDTH and the IDLE/ISSUE/WAIT encodings as defines; reuse DATA_WIDTH.
- One natural sub-module: rr_picker_2.
  - Combinational 2-way pick from (req_a, req_b, last_grant, priority_en).
  - Reusable for a future DMA port.

Test Plan:
1. Reset (reset=0 for 2 cycles) with mem_rvalid=1 and both reqs high -> all outputs 0, state IDLE; after release, fetch is granted first.
2. Fetch alone, addr=0x100, mem_ready same cycle, mem_rvalid 2 cycles later with 0xDEADBEEF -> mem_addr=0x100, mem_we=0, fetch_gnt one pulse, fetch_rvalid with rdata=0xDEADBEEF; lsu outputs stay 0.
3. Both requesting continuously, LSU_PRIORITY=0, 6 transactions -> grant order fetch, lsu, fetch, lsu, fetch, lsu. With LSU_PRIORITY=1 -> all 6 go to lsu.
4. LSU write, addr=0x2000, wdata=0x12345678, wmask=4'b0011, mem_ready delayed 3 cycles -> mem_req high 3+1 cycles with fields stable; lsu_gnt on the ready cycle; lsu_rvalid on ack.
5. TIMEOUT_CYCLES=4, no mem_rvalid -> lsu_err pulses on the 4th WAIT cycle; then IDLE; a late mem_rvalid is dropped with no rvalid. Also rvalid on the exact timeout cycle -> rvalid=1, err=0.
6. Reset deasserted→asserted (reset=0) during WAIT -> next cycle IDLE; no err and no rvalid; subsequent mem_rvalid ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-requester memory port arbiter.
// The state and owner enums are shared by the arbiter and anything that observes it.
package mem_port_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arbState_t;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LSU   = 1'b1
  } owner_t;

  // Counter width able to hold 0 .. cycles-1, never narrower than one bit.
  function automatic int cntWidth(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker_2.sv
// Combinational two-way picker: round-robin between a and b, or b-wins-ties.
// last_grant: 1 = b was granted most recently.
module rr_picker_2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  input  logic priority_en,
  output logic gnt_valid,
  output logic gnt_b
);

  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_b     = 1'b0;
    if (req_a && req_b) begin
      gnt_b = priority_en | ~last_grant;
    end else begin
      gnt_b = req_b;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU.
// One outstanding transaction, round-robin or LSU-priority, with a response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LSU_PRIORITY   = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [DATA_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic                  fetch_err,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [DATA_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [3:0]            lsu_wmask,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic                  lsu_err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int             CNT_W   = cntWidth(TIMEOUT_CYCLES);
  localparam logic           TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic           PRIO_EN = (LSU_PRIORITY != 0);

  arbState_t        state;
  owner_t           owner;
  owner_t           lastGrant;
  logic [CNT_W-1:0] waitCnt;

  logic pickValid;
  logic pickLsu;
  logic issueAccept;
  logic respHit;
  logic timeoutHit;

  rr_picker_2 u_picker (
    .req_a       (fetch_req),
    .req_b       (lsu_req),
    .last_grant  (lastGrant == OWNER_LSU),
    .priority_en (PRIO_EN),
    .gnt_valid   (pickValid),
    .gnt_b       (pickLsu)
  );

  assign rdata = mem_rdata;

  // Handshake pulses are decoded from the registered state; gating with reset
  // keeps an aborted transaction from emitting gnt/rvalid/err in the reset cycle.
  always_comb begin
    issueAccept  = reset && (state == ARB_ISSUE) && mem_ready;
    respHit      = reset && (state == ARB_WAIT) && mem_rvalid;
    timeoutHit   = reset && TO_EN && (state == ARB_WAIT) && !mem_rvalid &&
                   (waitCnt == TO_LAST);
    fetch_gnt    = issueAccept && (owner == OWNER_FETCH);
    lsu_gnt      = issueAccept && (owner == OWNER_LSU);
    fetch_rvalid = respHit && (owner == OWNER_FETCH);
    lsu_rvalid   = respHit && (owner == OWNER_LSU);
    fetch_err    = timeoutHit && (owner == OWNER_FETCH);
    lsu_err      = timeoutHit && (owner == OWNER_LSU);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB_IDLE;
      owner     <= OWNER_FETCH;
      lastGrant <= OWNER_LSU;
      waitCnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pickValid) begin
            mem_req <= 1'b1;
            state   <= ARB_ISSUE;
            if (pickLsu) begin
              owner     <= OWNER_LSU;
              mem_we    <= lsu_we;
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
              mem_wmask <= lsu_wmask;
            end else begin
              owner     <= OWNER_FETCH;
              mem_we    <= 1'b0;
              mem_addr  <= fetch_addr;
              mem_wdata <= '0;
              mem_wmask <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          if (issueAccept) begin
            mem_req   <= 1'b0;
            lastGrant <= owner;
            waitCnt   <= '0;
            state     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          if (respHit || timeoutHit) begin
            state <= ARB_IDLE;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed tables, hand sequences and a randomized
// transaction-level model of arbitration order and response/timeout outcome.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        fetch_gnt, fetch_rvalid, fetch_err, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_wmask;

  logic        d1FetchGnt, d1FetchRvalid, d1FetchErr, d1LsuGnt, d1LsuRvalid, d1LsuErr;
  logic [31:0] d1Rdata, d1MemAddr, d1MemWdata;
  logic        d1MemReq, d1MemWe;
  logic [3:0]  d1MemWmask;

  logic [5:0] f0, f1;
  assign f0 = {fetch_gnt, fetch_rvalid, fetch_err, lsu_gnt, lsu_rvalid, lsu_err};
  assign f1 = {d1FetchGnt, d1FetchRvalid, d1FetchErr, d1LsuGnt, d1LsuRvalid, d1LsuErr};

  mem_port_arbiter #(.DATA_WIDTH(32), .LSU_PRIORITY(0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_err(fetch_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_err(lsu_err),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DATA_WIDTH(32), .LSU_PRIORITY(1), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(d1FetchGnt), .fetch_rvalid(d1FetchRvalid), .fetch_err(d1FetchErr),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_gnt(d1LsuGnt), .lsu_rvalid(d1LsuRvalid), .lsu_err(d1LsuErr),
    .rdata(d1Rdata), .mem_req(d1MemReq), .mem_we(d1MemWe), .mem_addr(d1MemAddr),
    .mem_wdata(d1MemWdata), .mem_wmask(d1MemWmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Expected flag vector {fgnt,frvalid,ferr,lgnt,lrvalid,lerr} for one owner.
  function automatic logic [5:0] mk(input logic isLsu, input logic g, input logic v, input logic e);
    return isLsu ? {3'b000, g, v, e} : {g, v, e, 3'b000};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0; fetch_req = 1'b0; lsu_req = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  // Runs one transaction on dut0; requests are already driven in an IDLE cycle.
  task automatic doTxn(input string tag, input logic own, input logic we,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] msk,
                       input int rdy, input int rsp, input logic [31:0] rd, input logic expErr);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #4 chk({tag, "/idle_flags"}, 32'(f0), 32'(6'b0));
    cyc();
    for (int k = 0; k <= rdy; k++) begin
      mem_ready = (k == rdy);
      #4;
      chk({tag, "/mem_req"}, 32'(mem_req), 32'(1));
      chk({tag, "/mem_addr"}, mem_addr, addr);
      chk({tag, "/mem_we"}, 32'(mem_we), 32'(we));
      if (own) begin
        chk({tag, "/mem_wdata"}, mem_wdata, wd);
        chk({tag, "/mem_wmask"}, 32'(mem_wmask), 32'(msk));
      end
      chk({tag, "/issue_flags"}, 32'(f0), 32'((k == rdy) ? mk(own, 1'b1, 1'b0, 1'b0) : 6'b0));
      cyc();
    end
    mem_ready = 1'b0;
    if (own) lsu_req = 1'b0; else fetch_req = 1'b0;
    for (int w = 0; w < TO + 2; w++) begin
      mem_rvalid = (w == rsp);
      mem_rdata  = rd;
      #4;
      if (w == 0) chk({tag, "/wait_mem_req"}, 32'(mem_req), 32'(0));
      if (!expErr && w == rsp) begin
        chk({tag, "/resp_flags"}, 32'(f0), 32'(mk(own, 1'b0, 1'b1, 1'b0)));
        chk({tag, "/rdata"}, rdata, rd);
      end else if (expErr && w == TO - 1) begin
        chk({tag, "/timeout_flags"}, 32'(f0), 32'(mk(own, 1'b0, 1'b0, 1'b1)));
      end else begin
        chk({tag, "/wait_flags"}, 32'(f0), 32'(6'b0));
      end
      cyc();
      if ((!expErr && w == rsp) || (expErr && w == TO - 1)) break;
    end
    mem_rvalid = 1'b0;
  endtask

  typedef struct {
    logic        fReq;
    logic [31:0] fAddr;
    logic        lReq;
    logic        lWe;
    logic [31:0] lAddr;
    logic [31:0] lWdata;
    logic [3:0]  lMask;
    int          rdy;
    int          rsp;
    logic [31:0] rd;
    logic        expLsu;
    logic        expWe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic [3:0]  expMask;
    logic        expErr;
  } vec_t;

  vec_t vecs[7];
  int   q0[$];
  int   q1[$];

  logic        pf, pl, plWe, modelLast, own;
  logic [31:0] pfAddr, plAddr, plWdata;
  logic [3:0]  plMask;
  int          rdy, rsp;

  initial begin
    // Starts right after reset: last grant is LSU, so fetch wins the first tie.
    vecs[0] = '{1, 32'h100, 0, 0, 32'h0,    32'h0,        4'b0000, 0, 1, 32'hDEADBEEF, 0, 0, 32'h100,  32'h0,        4'b0000, 0};
    vecs[1] = '{0, 32'h0,   1, 1, 32'h2000, 32'h12345678, 4'b0011, 3, 0, 32'h0,        1, 1, 32'h2000, 32'h12345678, 4'b0011, 0};
    vecs[2] = '{1, 32'h400, 1, 0, 32'h3000, 32'h0,        4'b0000, 1, 2, 32'h11112222, 0, 0, 32'h400,  32'h0,        4'b0000, 0};
    vecs[3] = '{1, 32'h404, 1, 0, 32'h3000, 32'h0,        4'b0000, 0, 3, 32'h33334444, 1, 0, 32'h3000, 32'h0,        4'b0000, 0};
    vecs[4] = '{1, 32'h404, 1, 1, 32'h3004, 32'hA5A5A5A5, 4'b1100, 2, 5, 32'h0,        0, 0, 32'h404,  32'h0,        4'b0000, 1};
    vecs[5] = '{0, 32'h0,   1, 1, 32'h3004, 32'hA5A5A5A5, 4'b1100, 0, 0, 32'h55AA55AA, 1, 1, 32'h3004, 32'hA5A5A5A5, 4'b1100, 0};
    vecs[6] = '{1, 32'h800, 1, 0, 32'h7000, 32'h0,        4'b0000, 0, 4, 32'h0,        0, 0, 32'h800,  32'h0,        4'b0000, 1};

    // Reset with both requests and a stray response present.
    reset = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h100;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h2000; lsu_wdata = 32'h12345678; lsu_wmask = 4'b0011;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF0000;
    repeat (2) begin
      cyc();
      #4;
      chk("reset/flags0", 32'(f0), 32'(6'b0));
      chk("reset/flags1", 32'(f1), 32'(6'b0));
      chk("reset/mem_req", 32'(mem_req), 32'(0));
      chk("reset/mem_we", 32'(mem_we), 32'(0));
      chk("reset/mem_addr", mem_addr, 32'h0);
      chk("reset/mem_wdata", mem_wdata, 32'h0);
      chk("reset/mem_wmask", 32'(mem_wmask), 32'(0));
    end
    cyc();
    reset = 1'b1;
    // Continuous requests, memory always ready and responding: 3 cycles per transaction.
    for (int c = 0; c < 18; c++) begin
      #4;
      if (fetch_gnt) q0.push_back(0);
      if (lsu_gnt) q0.push_back(1);
      if (d1FetchGnt) q1.push_back(0);
      if (d1LsuGnt) q1.push_back(1);
      cyc();
    end
    chk("rr/count", 32'(q0.size()), 32'd6);
    chk("prio/count", 32'(q1.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < q0.size()) chk($sformatf("rr/order%0d", i), 32'(q0[i]), 32'(i % 2));
      if (i < q1.size()) chk($sformatf("prio/order%0d", i), 32'(q1[i]), 32'd1);
    end

    applyReset();
    for (int i = 0; i < 7; i++) begin
      fetch_req = vecs[i].fReq; fetch_addr = vecs[i].fAddr;
      lsu_req = vecs[i].lReq; lsu_we = vecs[i].lWe; lsu_addr = vecs[i].lAddr;
      lsu_wdata = vecs[i].lWdata; lsu_wmask = vecs[i].lMask;
      doTxn($sformatf("vec%0d", i), vecs[i].expLsu, vecs[i].expWe, vecs[i].expAddr,
            vecs[i].expWdata, vecs[i].expMask, vecs[i].rdy, vecs[i].rsp, vecs[i].rd, vecs[i].expErr);
    end

    // Timeout then late response: dut0 drops it, dut1 (watchdog off) still takes it.
    applyReset();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h5000;
    cyc();
    mem_ready = 1'b1;
    #4 chk("to/gnt", 32'(f0), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0)));
    cyc();
    mem_ready = 1'b0; lsu_req = 1'b0;
    for (int w = 0; w < TO; w++) begin
      #4;
      chk($sformatf("to/wait%0d", w), 32'(f0), 32'((w == TO - 1) ? mk(1'b1, 1'b0, 1'b0, 1'b1) : 6'b0));
      chk($sformatf("to/d1wait%0d", w), 32'(f1), 32'(6'b0));
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    #4;
    chk("to/late_drop", 32'(f0), 32'(6'b0));
    chk("to/d1_late_take", 32'(f1), 32'(mk(1'b1, 1'b0, 1'b1, 1'b0)));
    cyc();
    mem_rvalid = 1'b0;
    #4;
    chk("to/idle_mem_req", 32'(mem_req), 32'(0));
    chk("to/idle_flags", 32'(f0), 32'(6'b0));
    cyc();

    // Reset during WAIT with a response arriving in the same cycle.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h6000;
    cyc();
    mem_ready = 1'b1;
    #4 chk("rstw/gnt", 32'(f0), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0)));
    cyc();
    mem_ready = 1'b0; lsu_req = 1'b0;
    #4 chk("rstw/wait0", 32'(f0), 32'(6'b0));
    cyc();
    reset = 1'b0; mem_rvalid = 1'b1;
    #4;
    chk("rstw/rst_flags0", 32'(f0), 32'(6'b0));
    chk("rstw/rst_flags1", 32'(f1), 32'(6'b0));
    cyc();
    reset = 1'b1;
    for (int c = 0; c < TO + 1; c++) begin
      #4;
      chk($sformatf("rstw/after%0d", c), 32'(f0), 32'(6'b0));
      chk($sformatf("rstw/mem_req%0d", c), 32'(mem_req), 32'(0));
      cyc();
    end
    mem_rvalid = 1'b0;

    // Randomized transactions against a pending-request model.
    applyReset();
    pf = 1'b0; pl = 1'b0; modelLast = 1'b1;
    pfAddr = '0; plAddr = '0; plWdata = '0; plMask = '0; plWe = 1'b0;
    for (int t = 0; t < 150; t++) begin
      if (!pf && $urandom_range(0, 1) == 1) begin
        pf = 1'b1; pfAddr = $urandom;
      end
      if (!pl && $urandom_range(0, 1) == 1) begin
        pl = 1'b1; plWe = 1'($urandom_range(0, 1)); plAddr = $urandom;
        plWdata = $urandom; plMask = 4'($urandom);
      end
      if (!pf && !pl) begin
        pf = 1'b1; pfAddr = $urandom;
      end
      own = (pf && pl) ? !modelLast : pl;
      fetch_req = pf; fetch_addr = pfAddr;
      lsu_req = pl; lsu_we = plWe; lsu_addr = plAddr; lsu_wdata = plWdata; lsu_wmask = plMask;
      rdy = $urandom_range(0, 3);
      rsp = $urandom_range(0, 5);
      doTxn($sformatf("rand%0d", t), own, own ? plWe : 1'b0, own ? plAddr : pfAddr,
            own ? plWdata : 32'h0, own ? plMask : 4'h0, rdy, rsp, $urandom, rsp >= TO);
      modelLast = own;
      if (own) pl = 1'b0; else pf = 1'b0;
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
